// File: rtl/dru_ctrl_pkg.sv
// Shared types and defaults for the DRU sequencing controller.
//   state_t    : 3-bit FSM state codes exported on o_state
//   gain_set_t : one set of loop gains {g1, g1_p, g2}
//   DEF_*      : default parameter values
//   max4       : used to size the shared phase counter
package dru_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RESET  = 3'd1,
        ST_ACQ    = 3'd2,
        ST_VERIFY = 3'd3,
        ST_TRACK  = 3'd4,
        ST_RELOCK = 3'd5
    } state_t;

    typedef struct packed {
        logic [4:0] g1;
        logic [4:0] g1_p;
        logic [4:0] g2;
    } gain_set_t;

    localparam int unsigned DEF_RST_CYCLES     = 16;
    localparam int unsigned DEF_ACQ_CYCLES     = 4096;
    localparam int unsigned DEF_LOCK_HOLD      = 256;
    localparam int unsigned DEF_ALARM_DEBOUNCE = 64;
    localparam int unsigned DEF_RELOCK_CNT_W   = 8;

    function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                         input int unsigned c, input int unsigned d);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/dru_ctrl_runlen.sv
// Consecutive-cycle detector.
//   i_clk, i_nrst : clock, asynchronous active-low reset
//   i_inc         : qualifying condition present this cycle
//   i_clr         : restart the run (takes priority over i_inc)
//   o_hit         : run length including the current cycle has reached THRESH
module dru_ctrl_runlen
    import dru_ctrl_pkg::*;
#(
    parameter int unsigned THRESH = DEF_ALARM_DEBOUNCE
) (
    input  logic i_clk,
    input  logic i_nrst,
    input  logic i_inc,
    input  logic i_clr,
    output logic o_hit
);

    localparam int unsigned   CW  = $clog2(THRESH) + 1;
    localparam logic [CW-1:0] THR = CW'(THRESH);

    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;

    // Saturates at THRESH so the counter never wraps on long runs.
    always_comb begin
        w_cnt_nxt = r_cnt;
        if (i_clr)
            w_cnt_nxt = '0;
        else if (i_inc && (r_cnt < THR))
            w_cnt_nxt = r_cnt + 1'b1;
    end

    // Hit looks at the updated count so the decision lands on the THRESH-th cycle.
    assign o_hit = (w_cnt_nxt >= THR);

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst)
            r_cnt <= '0;
        else
            r_cnt <= w_cnt_nxt;
    end

endmodule

// File: rtl/dru_ctrl.sv
// DRU sequencing controller: IDLE -> RESET -> ACQ -> VERIFY -> TRACK, with
// automatic RELOCK on debounced AL_PPM alarms or on request.
//   i_clk, i_nrst        : clock (shared with DRU), asynchronous active-low reset
//   i_enable             : run level; low returns to IDLE
//   i_cfg_*              : center frequency and acq/track gains, snapshotted on
//                          entry to RESET or RELOCK
//   i_relock_req         : pulse, forces RELOCK from VERIFY/TRACK
//   i_pl_req, i_pl_phase : phase-load request, honoured in VERIFY/TRACK
//   i_al_ppm             : DRU frequency alarm
//   o_dru_*, o_center_f, o_g*, o_pl, o_phase_in : registered DRU controls
//   o_locked, o_state, o_relock_cnt             : status
module dru_ctrl
    import dru_ctrl_pkg::*;
#(
    parameter int unsigned RST_CYCLES     = DEF_RST_CYCLES,
    parameter int unsigned ACQ_CYCLES     = DEF_ACQ_CYCLES,
    parameter int unsigned LOCK_HOLD      = DEF_LOCK_HOLD,
    parameter int unsigned ALARM_DEBOUNCE = DEF_ALARM_DEBOUNCE,
    parameter int unsigned RELOCK_CNT_W   = DEF_RELOCK_CNT_W
) (
    input  logic                    i_clk,
    input  logic                    i_nrst,
    input  logic                    i_enable,
    input  logic [36:0]             i_cfg_center_f,
    input  logic [4:0]              i_cfg_g1_acq,
    input  logic [4:0]              i_cfg_g1p_acq,
    input  logic [4:0]              i_cfg_g2_acq,
    input  logic [4:0]              i_cfg_g1_trk,
    input  logic [4:0]              i_cfg_g1p_trk,
    input  logic [4:0]              i_cfg_g2_trk,
    input  logic                    i_relock_req,
    input  logic                    i_pl_req,
    input  logic [31:0]             i_pl_phase,
    input  logic                    i_al_ppm,
    output logic                    o_dru_rst,
    output logic                    o_dru_rst_freq,
    output logic                    o_dru_en,
    output logic [36:0]             o_center_f,
    output logic [4:0]              o_g1,
    output logic [4:0]              o_g1_p,
    output logic [4:0]              o_g2,
    output logic                    o_pl,
    output logic [31:0]             o_phase_in,
    output logic                    o_locked,
    output logic [2:0]              o_state,
    output logic [RELOCK_CNT_W-1:0] o_relock_cnt
);

    localparam int unsigned CNT_W =
        $clog2(max4(RST_CYCLES, ACQ_CYCLES, LOCK_HOLD, ALARM_DEBOUNCE)) + 1;
    localparam logic [CNT_W-1:0] RST_LOAD = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] ACQ_LOAD = CNT_W'(ACQ_CYCLES - 1);

    state_t              r_state;
    state_t              w_next;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_cnt_nxt;

    logic [36:0]         r_snap_cf;
    gain_set_t           r_snap_acq;
    gain_set_t           r_snap_trk;
    logic [36:0]         w_snap_cf;
    gain_set_t           w_snap_acq;
    gain_set_t           w_snap_trk;
    logic                w_take;

    logic                w_rl_active;
    logic                w_alarm_clr;
    logic                w_clean_clr;
    logic                w_clean_inc;
    logic                w_alarm_hit;
    logic                w_clean_hit;
    logic                w_relock_go;
    logic                w_relock_entry;
    logic                w_pl_accept;

    logic                w_rst;
    logic                w_rst_freq;
    logic                w_en;
    gain_set_t           w_gains;
    logic                w_locked;

    logic                r_dru_rst;
    logic                r_dru_rst_freq;
    logic                r_dru_en;
    logic [36:0]         r_center_f;
    gain_set_t           r_gains;
    logic                r_pl;
    logic [31:0]         r_phase_in;
    logic                r_locked;
    logic [RELOCK_CNT_W-1:0] r_relock_cnt;

    // Run-length detectors only count while the loop is being judged; outside
    // VERIFY/TRACK they are held clear, which gives the clear-on-VERIFY-entry.
    assign w_rl_active = (r_state == ST_VERIFY) || (r_state == ST_TRACK);
    assign w_alarm_clr = !w_rl_active || !i_al_ppm;
    assign w_clean_clr = !w_rl_active || i_al_ppm;
    assign w_clean_inc = !i_al_ppm;

    dru_ctrl_runlen #(.THRESH(ALARM_DEBOUNCE)) u_alarm (
        .i_clk (i_clk),
        .i_nrst(i_nrst),
        .i_inc (i_al_ppm),
        .i_clr (w_alarm_clr),
        .o_hit (w_alarm_hit)
    );

    dru_ctrl_runlen #(.THRESH(LOCK_HOLD)) u_clean (
        .i_clk (i_clk),
        .i_nrst(i_nrst),
        .i_inc (w_clean_inc),
        .i_clr (w_clean_clr),
        .o_hit (w_clean_hit)
    );

    assign w_relock_go = i_relock_req || w_alarm_hit;

    // State register, phase counter and configuration snapshot.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_snap_cf  <= '0;
            r_snap_acq <= '0;
            r_snap_trk <= '0;
        end else begin
            r_state    <= w_next;
            r_cnt      <= w_cnt_nxt;
            r_snap_cf  <= w_snap_cf;
            r_snap_acq <= w_snap_acq;
            r_snap_trk <= w_snap_trk;
        end
    end

    // Next-state logic; the shared counter counts down to 0 in RESET/ACQ/RELOCK.
    always_comb begin
        w_next    = r_state;
        w_cnt_nxt = r_cnt;
        if (!i_enable) begin
            w_next    = ST_IDLE;
            w_cnt_nxt = '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    w_next    = ST_RESET;
                    w_cnt_nxt = RST_LOAD;
                end
                ST_RESET, ST_RELOCK: begin
                    if (r_cnt == '0) begin
                        w_next    = ST_ACQ;
                        w_cnt_nxt = ACQ_LOAD;
                    end else begin
                        w_cnt_nxt = r_cnt - 1'b1;
                    end
                end
                ST_ACQ: begin
                    if (r_cnt == '0) begin
                        w_next    = ST_VERIFY;
                        w_cnt_nxt = '0;
                    end else begin
                        w_cnt_nxt = r_cnt - 1'b1;
                    end
                end
                ST_VERIFY: begin
                    if (w_relock_go) begin
                        w_next    = ST_RELOCK;
                        w_cnt_nxt = RST_LOAD;
                    end else if (w_clean_hit) begin
                        w_next = ST_TRACK;
                    end
                end
                ST_TRACK: begin
                    if (w_relock_go) begin
                        w_next    = ST_RELOCK;
                        w_cnt_nxt = RST_LOAD;
                    end
                end
                default: begin
                    w_next    = ST_IDLE;
                    w_cnt_nxt = '0;
                end
            endcase
        end
    end

    // Output decode is driven from the next state so every registered output
    // lines up with the o_state value shown in the same cycle.
    always_comb begin
        w_take = ((w_next == ST_RESET)  && (r_state != ST_RESET)) ||
                 ((w_next == ST_RELOCK) && (r_state != ST_RELOCK));
        w_snap_cf  = r_snap_cf;
        w_snap_acq = r_snap_acq;
        w_snap_trk = r_snap_trk;
        if (w_take) begin
            w_snap_cf  = i_cfg_center_f;
            w_snap_acq = '{g1: i_cfg_g1_acq, g1_p: i_cfg_g1p_acq, g2: i_cfg_g2_acq};
            w_snap_trk = '{g1: i_cfg_g1_trk, g1_p: i_cfg_g1p_trk, g2: i_cfg_g2_trk};
        end

        w_relock_entry = (w_next == ST_RELOCK) && (r_state != ST_RELOCK);
        // A relock in the same cycle swallows the phase-load request.
        w_pl_accept    = i_pl_req && w_rl_active && (w_next != ST_RELOCK);

        w_rst      = 1'b1;
        w_rst_freq = 1'b1;
        w_en       = 1'b0;
        w_gains    = '0;
        w_locked   = 1'b0;
        unique case (w_next)
            ST_IDLE: ;
            ST_RESET: begin
                w_en    = 1'b1;
                w_gains = w_snap_acq;
            end
            ST_ACQ: begin
                w_rst      = 1'b0;
                w_rst_freq = 1'b0;
                w_en       = 1'b1;
                w_gains    = w_snap_acq;
            end
            ST_VERIFY: begin
                w_rst      = 1'b0;
                w_rst_freq = 1'b0;
                w_en       = 1'b1;
                w_gains    = w_snap_trk;
            end
            ST_TRACK: begin
                w_rst      = 1'b0;
                w_rst_freq = 1'b0;
                w_en       = 1'b1;
                w_gains    = w_snap_trk;
                w_locked   = 1'b1;
            end
            ST_RELOCK: begin
                w_rst   = 1'b0;
                w_en    = 1'b1;
                w_gains = w_snap_acq;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_dru_rst      <= 1'b1;
            r_dru_rst_freq <= 1'b1;
            r_dru_en       <= 1'b0;
            r_center_f     <= '0;
            r_gains        <= '0;
            r_pl           <= 1'b0;
            r_phase_in     <= '0;
            r_locked       <= 1'b0;
            r_relock_cnt   <= '0;
        end else begin
            r_dru_rst      <= w_rst;
            r_dru_rst_freq <= w_rst_freq;
            r_dru_en       <= w_en;
            r_center_f     <= w_snap_cf;
            r_gains        <= w_gains;
            r_locked       <= w_locked;
            r_pl           <= w_pl_accept;
            if (w_pl_accept)
                r_phase_in <= i_pl_phase;
            if (w_relock_entry && (r_relock_cnt != '1))
                r_relock_cnt <= r_relock_cnt + 1'b1;
        end
    end

    assign o_dru_rst      = r_dru_rst;
    assign o_dru_rst_freq = r_dru_rst_freq;
    assign o_dru_en       = r_dru_en;
    assign o_center_f     = r_center_f;
    assign o_g1           = r_gains.g1;
    assign o_g1_p         = r_gains.g1_p;
    assign o_g2           = r_gains.g2;
    assign o_pl           = r_pl;
    assign o_phase_in     = r_phase_in;
    assign o_locked       = r_locked;
    assign o_state        = r_state;
    assign o_relock_cnt   = r_relock_cnt;

endmodule

// File: tb/tb_dru_ctrl.sv
module tb_dru_ctrl;

    localparam int unsigned P_RST  = 4;
    localparam int unsigned P_ACQ  = 8;
    localparam int unsigned P_LOCK = 5;
    localparam int unsigned P_DEB  = 3;
    localparam int unsigned P_RCW  = 8;

    logic        clk = 1'b0;
    logic        nrst;
    logic        enable;
    logic [36:0] cfg_cf;
    logic [4:0]  g1a, g1pa, g2a, g1t, g1pt, g2t;
    logic        relock_req, pl_req, al;
    logic [31:0] pl_phase;

    logic        o_dru_rst, o_dru_rst_freq, o_dru_en, o_pl, o_locked;
    logic [36:0] o_center_f;
    logic [4:0]  o_g1, o_g1_p, o_g2;
    logic [31:0] o_phase_in;
    logic [2:0]  o_state;
    logic [P_RCW-1:0] o_relock_cnt;

    int checks = 0;
    int errors = 0;

    // Behavioural reference: phase durations counted up, run lengths as ints.
    int          m_state, m_elapsed, m_clean, m_alarm, m_relocks;
    logic [36:0] m_cf;
    logic [14:0] m_acq, m_trk;
    logic        m_pl;
    logic [31:0] m_phase;

    always #5 clk = ~clk;

    dru_ctrl #(
        .RST_CYCLES(P_RST), .ACQ_CYCLES(P_ACQ), .LOCK_HOLD(P_LOCK),
        .ALARM_DEBOUNCE(P_DEB), .RELOCK_CNT_W(P_RCW)
    ) dut (
        .i_clk(clk), .i_nrst(nrst), .i_enable(enable),
        .i_cfg_center_f(cfg_cf),
        .i_cfg_g1_acq(g1a), .i_cfg_g1p_acq(g1pa), .i_cfg_g2_acq(g2a),
        .i_cfg_g1_trk(g1t), .i_cfg_g1p_trk(g1pt), .i_cfg_g2_trk(g2t),
        .i_relock_req(relock_req), .i_pl_req(pl_req), .i_pl_phase(pl_phase),
        .i_al_ppm(al),
        .o_dru_rst(o_dru_rst), .o_dru_rst_freq(o_dru_rst_freq), .o_dru_en(o_dru_en),
        .o_center_f(o_center_f), .o_g1(o_g1), .o_g1_p(o_g1_p), .o_g2(o_g2),
        .o_pl(o_pl), .o_phase_in(o_phase_in), .o_locked(o_locked),
        .o_state(o_state), .o_relock_cnt(o_relock_cnt)
    );

    function automatic void model_reset();
        m_state = 0; m_elapsed = 1; m_clean = 0; m_alarm = 0; m_relocks = 0;
        m_cf = '0; m_acq = '0; m_trk = '0; m_pl = 1'b0; m_phase = '0;
    endfunction

    function automatic void model_step();
        int ns;
        bit accept;
        ns = m_state;
        if (m_state == 3 || m_state == 4) begin
            if (al) begin m_alarm++; m_clean = 0; end
            else    begin m_clean++; m_alarm = 0; end
        end
        if (!enable) ns = 0;
        else case (m_state)
            0: ns = 1;
            1: if (m_elapsed == P_RST) ns = 2;
            2: if (m_elapsed == P_ACQ) ns = 3;
            3: if (relock_req || m_alarm >= P_DEB) ns = 5;
               else if (m_clean >= P_LOCK) ns = 4;
            4: if (relock_req || m_alarm >= P_DEB) ns = 5;
            5: if (m_elapsed == P_RST) ns = 2;
            default: ns = 0;
        endcase
        accept = pl_req && (m_state == 3 || m_state == 4) && ns != 5;
        m_pl = accept;
        if (accept) m_phase = pl_phase;
        if (ns != m_state) begin
            m_elapsed = 1; m_clean = 0; m_alarm = 0;
            if (ns == 1 || ns == 5) begin
                m_cf = cfg_cf; m_acq = {g1a, g1pa, g2a}; m_trk = {g1t, g1pt, g2t};
            end
            if (ns == 5 && m_relocks < 255) m_relocks++;
        end else begin
            m_elapsed++;
        end
        m_state = ns;
    endfunction

    // Center frequency and gains in IDLE are don't-care apart from reset.
    function automatic logic [99:0] exp_vec();
        logic [14:0] g;
        logic [36:0] cf;
        g  = (m_state == 3 || m_state == 4) ? m_trk : m_acq;
        cf = m_cf;
        if (m_state == 0) begin g = '0; cf = '0; end
        return {m_state <= 1, (m_state <= 1 || m_state == 5), m_state != 0, cf, g,
                m_pl, m_phase, m_state == 4, 3'(m_state), 8'(m_relocks)};
    endfunction

    function automatic logic [99:0] obs_vec();
        logic [14:0] g;
        logic [36:0] cf;
        g  = {o_g1, o_g1_p, o_g2};
        cf = o_center_f;
        if (m_state == 0) begin g = '0; cf = '0; end
        return {o_dru_rst, o_dru_rst_freq, o_dru_en, cf, g, o_pl, o_phase_in,
                o_locked, o_state, o_relock_cnt};
    endfunction

    task automatic tick();
        @(posedge clk);
        if (nrst) model_step();
        #1;
    endtask

    task automatic wait_state(input logic [2:0] target, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (o_state == target) begin ok = 1'b1; break; end
            tick();
        end
        if (o_state == target) ok = 1'b1;
    endtask

    task automatic randomize_cfg();
        logic [63:0] w;
        w = {$urandom, $urandom};
        cfg_cf = w[36:0];
        g1a = 5'($urandom); g1pa = 5'($urandom); g2a = 5'($urandom);
        g1t = 5'($urandom); g1pt = 5'($urandom); g2t = 5'($urandom);
    endtask

    task automatic test_reset();
        nrst = 1'b0; enable = 1'b0; relock_req = 1'b0; pl_req = 1'b0; al = 1'b0;
        pl_phase = '0;
        randomize_cfg();
        model_reset();
        tick(); tick();
        checks++;
        if (obs_vec() !== exp_vec()) begin errors++;
            $display("FAIL reset_vec got %h want %h", obs_vec(), exp_vec()); end
        checks++;
        if ({o_center_f, o_g1, o_g1_p, o_g2} !== '0) begin errors++;
            $display("FAIL reset_cfg_out got %h want 0", {o_center_f, o_g1, o_g1_p, o_g2}); end
        nrst = 1'b1;
        tick(); tick();
        checks++;
        if (o_state !== 3'd0 || o_dru_rst !== 1'b1 || o_dru_en !== 1'b0) begin errors++;
            $display("FAIL idle_hold got state=%0d rst=%b en=%b want 0/1/0",
                     o_state, o_dru_rst, o_dru_en); end
    endtask

    task automatic test_lock_sequence();
        logic [2:0] want;
        enable = 1'b1; al = 1'b0;
        for (int t = 1; t <= 20; t++) begin
            tick();
            want = (t <= 4) ? 3'd1 : (t <= 12) ? 3'd2 : (t <= 17) ? 3'd3 : 3'd4;
            checks++;
            if (o_state !== want) begin errors++;
                $display("FAIL lock_seq_state t=%0d got %0d want %0d", t, o_state, want); end
            checks++;
            if (obs_vec() !== exp_vec()) begin errors++;
                $display("FAIL lock_seq_vec t=%0d got %h want %h", t, obs_vec(), exp_vec()); end
        end
        checks++;
        if (o_locked !== 1'b1 || {o_g1, o_g1_p, o_g2} !== {g1t, g1pt, g2t}) begin errors++;
            $display("FAIL track_gains got lk=%b g=%h want 1 %h", o_locked,
                     {o_g1, o_g1_p, o_g2}, {g1t, g1pt, g2t}); end
    endtask

    task automatic test_alarm_debounce();
        logic pat [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        int n;
        for (int i = 0; i < 6; i++) begin
            al = pat[i];
            tick();
            checks++;
            if (o_state !== ((i < 5) ? 3'd4 : 3'd5)) begin errors++;
                $display("FAIL debounce_state i=%0d got %0d", i, o_state); end
        end
        al = 1'b0;
        checks++;
        if (o_relock_cnt !== 8'd1 || o_locked !== 1'b0) begin errors++;
            $display("FAIL relock_cnt got %0d lk=%b want 1 0", o_relock_cnt, o_locked); end
        n = 0;
        while (o_state == 3'd5 && n < 20) begin
            checks++;
            if (o_dru_rst_freq !== 1'b1 || o_dru_rst !== 1'b0) begin errors++;
                $display("FAIL relock_rst got rf=%b r=%b want 1 0", o_dru_rst_freq, o_dru_rst); end
            n++;
            tick();
        end
        checks++;
        if (n != 4 || o_state !== 3'd2) begin errors++;
            $display("FAIL relock_len got %0d cycles then state %0d want 4 then 2", n, o_state); end
    endtask

    task automatic test_cfg_snapshot();
        logic [36:0] old_cf;
        bit ok;
        wait_state(3'd4, 60, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL snap_reach_track got %0d want 4", o_state); end
        old_cf = cfg_cf;
        cfg_cf = 37'h1_0000_0000;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (o_center_f !== old_cf) begin errors++;
                $display("FAIL snap_hold got %h want %h", o_center_f, old_cf); end
        end
        relock_req = 1'b1; tick(); relock_req = 1'b0;
        checks++;
        if (o_state !== 3'd5 || o_center_f !== 37'h1_0000_0000) begin errors++;
            $display("FAIL snap_take got st=%0d cf=%h want 5 100000000", o_state, o_center_f); end
    endtask

    task automatic test_phase_load();
        bit ok;
        wait_state(3'd4, 60, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL pl_reach_track got %0d want 4", o_state); end
        pl_phase = 32'hDEAD_BEEF; pl_req = 1'b1; tick(); pl_req = 1'b0;
        pl_phase = 32'h0BAD_F00D;
        checks++;
        if (o_pl !== 1'b1 || o_phase_in !== 32'hDEAD_BEEF) begin errors++;
            $display("FAIL pl_pulse got pl=%b ph=%h want 1 deadbeef", o_pl, o_phase_in); end
        tick();
        checks++;
        if (o_pl !== 1'b0 || o_phase_in !== 32'hDEAD_BEEF) begin errors++;
            $display("FAIL pl_single got pl=%b ph=%h want 0 deadbeef", o_pl, o_phase_in); end
        pl_req = 1'b1; relock_req = 1'b1; tick(); pl_req = 1'b0; relock_req = 1'b0;
        checks++;
        if (o_state !== 3'd5 || o_pl !== 1'b0 || o_phase_in !== 32'hDEAD_BEEF) begin errors++;
            $display("FAIL pl_vs_relock got st=%0d pl=%b ph=%h", o_state, o_pl, o_phase_in); end
        wait_state(3'd2, 20, ok);
        pl_phase = 32'h1234_5678; pl_req = 1'b1; tick(); pl_req = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (o_state !== 3'd2 || o_pl !== 1'b0 || o_phase_in !== 32'hDEAD_BEEF) begin errors++;
                $display("FAIL pl_in_acq got st=%0d pl=%b ph=%h", o_state, o_pl, o_phase_in); end
            tick();
        end
    endtask

    task automatic test_enable_drop();
        bit ok;
        wait_state(3'd3, 40, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL en_reach_verify got %0d want 3", o_state); end
        enable = 1'b0; tick();
        checks++;
        if (o_state !== 3'd0 || o_dru_rst !== 1'b1 || o_dru_en !== 1'b0 || o_locked !== 1'b0
            || o_relock_cnt !== 8'(m_relocks)) begin errors++;
            $display("FAIL enable_drop got st=%0d rst=%b en=%b lk=%b rc=%0d want 0 1 0 0 %0d",
                     o_state, o_dru_rst, o_dru_en, o_locked, o_relock_cnt, m_relocks); end
        checks++;
        if (obs_vec() !== exp_vec()) begin errors++;
            $display("FAIL enable_drop_vec got %h want %h", obs_vec(), exp_vec()); end
        enable = 1'b1;
    endtask

    task automatic test_saturation();
        bit ok;
        wait_state(3'd3, 40, ok);
        for (int r = 0; r < 300; r++) begin
            relock_req = 1'b1; tick(); relock_req = 1'b0;
            checks++;
            if (obs_vec() !== exp_vec()) begin errors++;
                $display("FAIL sat_vec r=%0d got %h want %h", r, obs_vec(), exp_vec()); end
            wait_state(3'd3, 40, ok);
            checks++;
            if (!ok) begin errors++; $display("FAIL sat_reach_verify got %0d want 3", o_state); end
        end
        checks++;
        if (o_relock_cnt !== 8'hFF) begin errors++;
            $display("FAIL relock_sat got %0d want 255", o_relock_cnt); end
        relock_req = 1'b1; tick(); relock_req = 1'b0;
        wait_state(3'd2, 20, ok);
        tick(); tick();
        #2 nrst = 1'b0;
        model_reset();
        #1;
        checks++;
        if (o_dru_rst !== 1'b1 || o_dru_rst_freq !== 1'b1 || o_dru_en !== 1'b0 ||
            o_pl !== 1'b0 || o_locked !== 1'b0 || o_state !== 3'd0 || o_relock_cnt !== '0 ||
            {o_center_f, o_g1, o_g1_p, o_g2, o_phase_in} !== '0) begin errors++;
            $display("FAIL async_reset got %h want rst=1 rf=1 others 0", obs_vec()); end
        #2 nrst = 1'b1;
        tick();
        checks++;
        if (obs_vec() !== exp_vec()) begin errors++;
            $display("FAIL post_reset_vec got %h want %h", obs_vec(), exp_vec()); end
    endtask

    task automatic test_random();
        int p;
        p = 10;
        for (int c = 0; c < 1500; c++) begin
            if (c % 50 == 0) p = ($urandom_range(0, 2) == 0) ? 70 : ($urandom_range(0, 1) ? 30 : 5);
            if ($urandom_range(0, 99) < 5) randomize_cfg();
            al         = ($urandom_range(0, 99) < p);
            relock_req = ($urandom_range(0, 99) < 2);
            pl_req     = ($urandom_range(0, 99) < 10);
            pl_phase   = $urandom;
            enable     = ($urandom_range(0, 199) != 0);
            tick();
            checks++;
            if (obs_vec() !== exp_vec()) begin errors++;
                $display("FAIL random_vec c=%0d got %h want %h", c, obs_vec(), exp_vec()); end
        end
        relock_req = 1'b0; pl_req = 1'b0; enable = 1'b1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_lock_sequence();
        test_alarm_debounce();
        test_cfg_snapshot();
        test_phase_load();
        test_enable_drop();
        test_saturation();
        enable = 1'b1;
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dru_ctrl.md
Name: dru_ctrl

Overview:
- Sequencing controller for the technology-wrapped data recovery unit (DRU).
- Drives the DRU's reset, frequency reset, enable, center frequency, loop gains and phase-load inputs.
- Steps through reset → frequency acquisition → lock verification → tracking, and monitors AL_PPM to re-lock automatically.
- Sits between the register/config bank and the DRU instance; exports lock status.

Parameters:
RST_CYCLES, 16, cycles DRU reset / frequency reset is held
ACQ_CYCLES, 4096, cycles spent with acquisition gains
LOCK_HOLD, 256, consecutive AL_PPM=0 cycles required to declare lock
ALARM_DEBOUNCE, 64, consecutive AL_PPM=1 cycles required to declare loss of lock
RELOCK_CNT_W, 8, width of the saturating relock counter

Ports:
i_clk  in  1  clock, shared with the DRU CLK
i_nrst  in  1  asynchronous reset, active-low
i_enable  in  1  level; 1 = run the DRU, 0 = return to IDLE
i_cfg_center_f  in  37  nominal center frequency word
i_cfg_g1_acq  in  5  acquisition G1
i_cfg_g1p_acq  in  5  acquisition G1_P
i_cfg_g2_acq  in  5  acquisition G2
i_cfg_g1_trk  in  5  tracking G1
i_cfg_g1p_trk  in  5  tracking G1_P
i_cfg_g2_trk  in  5  tracking G2
i_relock_req  in  1  single-cycle pulse; forces a relock
i_pl_req  in  1  single-cycle pulse; request a phase load
i_pl_phase  in  32  phase value sampled with i_pl_req
i_al_ppm  in  1  AL_PPM from the DRU
o_dru_rst  out  1  to RST
o_dru_rst_freq  out  1  to RST_FREQ
o_dru_en  out  1  to EN
o_center_f  out  37  to CENTER_F
o_g1  out  5  to G1
o_g1_p  out  5  to G1_P
o_g2  out  5  to G2
o_pl  out  1  to PL
o_phase_in  out  32  to PHASE_IN
o_locked  out  1  lock status
o_state  out  3  current FSM state code
o_relock_cnt  out  RELOCK_CNT_W  number of relocks, saturating

Behaviour:
- All outputs are registered.
- Reset values:
  - o_dru_rst = 1, o_dru_rst_freq = 1, o_dru_en = 0, o_pl = 0.
  - o_center_f, gains, o_phase_in = 0.
  - o_locked = 0, o_state = IDLE, o_relock_cnt = 0.
- State codes: IDLE=0, RESET=1, ACQ=2, VERIFY=3, TRACK=4, RELOCK=5.
- Configuration snapshot:
  - i_cfg_* are sampled only on entry to RESET or RELOCK and held in snapshot registers.
  - Config changes at any other time are ignored until the next entry to RESET or RELOCK.
- IDLE:
  - rst = 1, rst_freq = 1, en = 0.
  - i_enable = 1 → RESET; take the snapshot and load the counter with RST_CYCLES−1.
- RESET:
  - rst = 1, rst_freq = 1, en = 1; outputs are the acquisition gains and the snapshot center_f.
  - When the counter reaches 0 → ACQ; load the counter with ACQ_CYCLES−1.
- ACQ:
  - rst = 0, rst_freq = 0, acquisition gains.
  - i_al_ppm is ignored.
  - When the counter reaches 0 → VERIFY; clear both run-length counters.
- VERIFY:
  - Tracking gains.
  - LOCK_HOLD consecutive cycles with i_al_ppm = 0 → TRACK; o_locked = 1 from the first TRACK cycle.
  - ALARM_DEBOUNCE consecutive cycles with i_al_ppm = 1 → RELOCK.
  - Any toggle of i_al_ppm clears the opposing run counter.
- TRACK:
  - Tracking gains, o_locked = 1.
  - ALARM_DEBOUNCE consecutive alarm cycles, or i_relock_req → RELOCK.
  - o_locked drops to 0 in the same cycle the state becomes RELOCK.
- RELOCK:
  - rst = 0, rst_freq = 1, acquisition gains.
  - Take the snapshot; o_relock_cnt increments by 1 and saturates at all-ones.
  - Hold for RST_CYCLES → ACQ.
- i_relock_req in VERIFY behaves as in TRACK; it is ignored in IDLE, RESET, ACQ and RELOCK.
- Phase load:
  - i_pl_req is accepted only in VERIFY or TRACK.
  - Next cycle: o_pl = 1 for exactly one cycle, and o_phase_in = i_pl_phase; o_phase_in then holds.
  - Requests in other states are dropped.
  - i_pl_req and a RELOCK transition in the same cycle: the relock wins and the phase-load request is dropped.
- i_enable = 0 in any state → IDLE next cycle:
  - o_locked = 0; counters cleared.
  - o_relock_cnt is kept; only i_nrst clears it.
- Asynchronous reset mid-operation returns all outputs to their reset values immediately.
- Counter widths are $clog2 of the largest parameter + 1, with no wrap-around.

Decomposition:
- dru_ctrl_pkg:
  - state enum (3-bit) and its codes.
  - gain_set_t struct {g1, g1_p, g2}.
  - Default parameter constants.
- Sub-module dru_ctrl_runlen, instantiated twice (alarm and clean):
  - Consecutive-cycle detector: saturating counter with clear input.
  - Output `hit` when count ≥ THRESH.

Test Plan (RST_CYCLES=4, ACQ_CYCLES=8, LOCK_HOLD=5, ALARM_DEBOUNCE=3):
1. Reset release, i_enable=1, i_al_ppm=0 → RESET for 4 cycles (rst=1), ACQ for 8 cycles with acquisition gains, VERIFY for 5 cycles, then TRACK with o_locked=1 and tracking gains.
2. In TRACK, i_al_ppm = 1,1,0,1,1,1 → RELOCK only after the last 1; o_relock_cnt 0→1; rst_freq=1 for 4 cycles; then ACQ.
3. Change i_cfg_center_f during TRACK to 0x1_0000_0000 → o_center_f unchanged until i_relock_req; new value appears in the RELOCK cycle.
4. i_pl_req with phase 0xDEAD_BEEF in TRACK → o_pl high for exactly 1 cycle, o_phase_in = 0xDEADBEEF; the same request in ACQ → no o_pl.
5. i_enable dropped in VERIFY → IDLE next cycle, rst=1, en=0, o_locked=0, o_relock_cnt retained.
6. Force 300 relocks with RELOCK_CNT_W=8 → o_relock_cnt saturates at 255; async i_nrst low mid-ACQ → all outputs at their reset values immediately.
